ibex_mem_arbiter: RTL and testbench
===================================

Name: ibex_mem_arbiter

Overview:
- Two-requester arbiter between the Ibex core's instruction-fetch port and data port.
- Shares one single-port, 1-cycle-latency RAM (ram_1p) between them.
- Replaces ad hoc glue logic with a defined req/gnt/rvalid protocol, address-range checking with error responses, and starvation protection for the data port.
- Sits between ibex_core and ram_1p in the system top.

Parameters:
- MemStart, 32'h00000000, base address of RAM window; aligned to MemSize.
- MemSize, 65536, RAM window size in bytes; power of two, >= 4.
- StarveLimit, 4, consecutive lost-arbitration cycles after which data beats instr; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch data.
- instr_err_o  out  1  fetch error (out of range); qualified by rvalid.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid (loads and stores).
- data_rdata_o  out  32  load data.
- data_err_o  out  1  data error; qualified by rvalid.
- mem_req_o  out  1  RAM access.
- mem_we_o  out  1  RAM write.
- mem_be_o  out  4  RAM byte enables.
- mem_addr_o  out  32  RAM address.
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM read data, valid one cycle after mem_req_o.

Behaviour:
- Reset: when rst_i is high at a clock edge, all registers clear.
  - While rst_i is high, all outputs are 0, including gnt, rvalid and mem_req.
  - Starvation counter = 0.
  - A response pending when reset asserts is dropped; no rvalid appears after reset.
- Arbitration (combinational, every cycle):
  - Only one request asserted: that requester wins.
  - Both asserted: data wins if starve_q >= StarveLimit, else instr wins.
  - The winner's gnt_o is asserted in the same cycle; the loser's gnt_o = 0.
  - A requester must hold req and its fields stable until gnt.
- In range: (addr & ~(MemSize-1)) == MemStart.
  - In-range winner drives mem_req_o = 1 and mem_addr_o = the full address.
  - Instr winner: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
  - Data winner: mem_we_o, mem_be_o and mem_wdata_o pass through from the data port.
  - Out-of-range winner is still granted, but mem_req_o = 0 and the error is recorded for the response.
  - With no winner, all mem_* outputs = 0.
- Response pipeline: registers resp_valid_q, resp_owner_q (instr/data), resp_err_q and resp_we_q capture the grant.
  - In the cycle after a grant, exactly the owner's rvalid_o = 1.
  - rdata_o = mem_rdata_i for an in-range load or fetch; 0 for stores and for errors.
  - err_o = resp_err_q.
  - The non-owner's rvalid, rdata and err are 0.
- Throughput:
  - Back-to-back grants are allowed; one grant per cycle, one response per cycle.
  - A new grant in cycle N+1 coexists with the response for the cycle-N grant.
- Starvation counter (4-bit):
  - Increments when data_req_i && !data_gnt_o, saturating at StarveLimit.
  - Clears on data_gnt_o.
  - Holds when data_req_i = 0.
- No buffering: at most one transaction is outstanding per requester, matching Ibex (1 LSU outstanding).

Optional Feature:
- Macro: IBEX_ARB_PERF_EN.
- Defined: adds three 32-bit saturating output counters, cleared by rst_i.
  - perf_instr_gnt_o: counts instr grants.
  - perf_data_gnt_o: counts data grants.
  - perf_conflict_o: counts cycles in which both req_i are high.
- Undefined: the ports and logic are absent; the rest of the block is identical.

Decomposition:
- Package ibex_arb_pkg holds:
  - typedef enum logic {ARB_OWNER_INSTR, ARB_OWNER_DATA} arb_owner_e;
  - packed struct arb_resp_t {valid, owner, err, we};
  - localparam STARVE_CNT_W = 4.
- One sub-module, ibex_arb_perf_cnt: a 32-bit saturating counter with enable and synchronous clear. Instantiated three times, only under IBEX_ARB_PERF_EN.

Test Plan:
1. Instr-only fetch of 0x80, RAM word = 0x00000013 -> instr_gnt=1 the same cycle; next cycle instr_rvalid=1, instr_rdata=0x00000013, err=0.
2. Store to 0x100, data 0xDEADBEEF, be=4'hF; then load 0x100 -> store gets rvalid with rdata=0; load returns 0xDEADBEEF. With be=4'h1 on a second store of 0x000000AA, the load returns 0xDEADBEAA.
3. instr_req and data_req held high continuously, StarveLimit=4 -> instr wins 4 cycles, data is granted in the 5th, and the counter clears; the pattern repeats.
4. Data load at 0x00010000 (out of range) -> data_gnt=1, mem_req=0; next cycle data_rvalid=1, data_err=1, data_rdata=0.
5. Grant issued, then rst_i raised in the following cycle -> no rvalid is observed; after release, all outputs are 0 until the next req.
6. With IBEX_ARB_PERF_EN: 10 conflict cycles plus 3 solo data grants -> perf_conflict=10, and perf_instr_gnt plus perf_data_gnt equals the total number of grants.

Source files
------------

// File: rtl/ibex_arb_pkg.sv
// Shared types for the Ibex instruction/data memory arbiter.
package ibex_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    ARB_OWNER_INSTR,
    ARB_OWNER_DATA
  } arb_owner_e;

  typedef struct packed {
    logic       valid;
    arb_owner_e owner;
    logic       err;
    logic       we;
  } arb_resp_t;

endpackage

// File: rtl/ibex_arb_perf_cnt.sv
// 32-bit saturating event counter with enable and synchronous clear.
module ibex_arb_perf_cnt (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != 32'hFFFF_FFFF)) begin
      cnt_o <= cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Arbitrates Ibex fetch and data ports onto one 1-cycle-latency single-port RAM.
// Optional performance counters are built when IBEX_ARB_PERF_EN is defined.
module ibex_mem_arbiter
  import ibex_arb_pkg::*;
#(
  parameter logic [31:0] MemStart    = 32'h0000_0000,
  parameter int          MemSize     = 65536,
  parameter int          StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
`ifdef IBEX_ARB_PERF_EN
  ,
  output logic [31:0] perf_instr_gnt_o,
  output logic [31:0] perf_data_gnt_o,
  output logic [31:0] perf_conflict_o
`endif
);

  // Handshake: a requester holds req and its fields stable until gnt is seen
  // in the same cycle; exactly one rvalid follows on the next cycle for each gnt.
  localparam logic [31:0]             AddrMask  = ~(32'(MemSize) - 32'd1);
  localparam logic [STARVE_CNT_W-1:0] StarveLim = STARVE_CNT_W'(StarveLimit);

  logic [STARVE_CNT_W-1:0] starve_q;
  arb_resp_t               resp_d, resp_q;
  logic                    instr_in_range, data_in_range;
  logic                    instr_win, data_win, data_priority;

  assign instr_in_range = (instr_addr_i & AddrMask) == MemStart;
  assign data_in_range  = (data_addr_i & AddrMask) == MemStart;
  assign data_priority  = starve_q >= StarveLim;

  assign instr_win = !rst_i && instr_req_i && !(data_req_i && data_priority);
  assign data_win  = !rst_i && data_req_i && (!instr_req_i || data_priority);

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  // Out-of-range winners are granted but never reach the RAM.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (instr_win && instr_in_range) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i;
    end else if (data_win && data_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_comb begin
    resp_d = '0;
    if (instr_win) begin
      resp_d.valid = 1'b1;
      resp_d.owner = ARB_OWNER_INSTR;
      resp_d.err   = !instr_in_range;
    end else if (data_win) begin
      resp_d.valid = 1'b1;
      resp_d.owner = ARB_OWNER_DATA;
      resp_d.err   = !data_in_range;
      resp_d.we    = data_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q   <= '0;
      starve_q <= '0;
    end else begin
      resp_q <= resp_d;
      if (data_win) begin
        starve_q <= '0;
      end else if (data_req_i && (starve_q < StarveLim)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Responses are masked during reset so a grant pending at reset is dropped.
  logic        resp_live;
  logic [31:0] resp_rdata;

  assign resp_live  = resp_q.valid && !rst_i;
  assign resp_rdata = (resp_q.err || resp_q.we) ? 32'h0 : mem_rdata_i;

  assign instr_rvalid_o = resp_live && (resp_q.owner == ARB_OWNER_INSTR);
  assign data_rvalid_o  = resp_live && (resp_q.owner == ARB_OWNER_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? resp_rdata : 32'h0;
  assign data_rdata_o   = data_rvalid_o ? resp_rdata : 32'h0;
  assign instr_err_o    = instr_rvalid_o && resp_q.err;
  assign data_err_o     = data_rvalid_o && resp_q.err;

`ifdef IBEX_ARB_PERF_EN
  ibex_arb_perf_cnt u_perf_instr (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (instr_win),
    .cnt_o (perf_instr_gnt_o)
  );

  ibex_arb_perf_cnt u_perf_data (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (data_win),
    .cnt_o (perf_data_gnt_o)
  );

  ibex_arb_perf_cnt u_perf_conflict (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  (instr_req_i && data_req_i),
    .cnt_o (perf_conflict_o)
  );
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed self-checking bench for ibex_mem_arbiter with a behavioural 1-cycle RAM.
module tb_ibex_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IBEX_ARB_PERF_EN
  logic [31:0] perf_instr_gnt, perf_data_gnt, perf_conflict;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  ibex_mem_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
`ifdef IBEX_ARB_PERF_EN
    ,
    .perf_instr_gnt_o (perf_instr_gnt),
    .perf_data_gnt_o  (perf_data_gnt),
    .perf_conflict_o  (perf_conflict)
`endif
  );

  // ram_1p stand-in: read data appears the cycle after mem_req.
  always @(posedge clk) begin
    if (mem_req) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we && mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"}, {30'd0, instr_gnt, data_gnt}, 32'd0);
    chk({tag, " rvalid"}, {30'd0, instr_rvalid, data_rvalid}, 32'd0);
    chk({tag, " err"}, {30'd0, instr_err, data_err}, 32'd0);
    chk({tag, " rdata"}, instr_rdata | data_rdata, 32'd0);
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " mem_fields"}, mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 32'd0);
  endtask

  // One solo data transaction: request cycle, then response cycle.
  task automatic data_txn(input string tag, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_mreq, input logic [31:0] exp_rdata,
                          input logic exp_err);
    data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
    #1;
    chk({tag, " data_gnt"}, {31'd0, data_gnt}, 32'd1);
    chk({tag, " instr_gnt"}, {31'd0, instr_gnt}, 32'd0);
    chk({tag, " mem_req"}, {31'd0, mem_req}, {31'd0, exp_mreq});
    if (exp_mreq) begin
      chk({tag, " mem_addr"}, mem_addr, addr);
      chk({tag, " mem_we_be"}, {27'd0, mem_we, mem_be}, {27'd0, we, be});
      chk({tag, " mem_wdata"}, mem_wdata, wdata);
    end
    tick();
    data_req = 1'b0;
    #1;
    chk({tag, " data_rvalid"}, {31'd0, data_rvalid}, 32'd1);
    chk({tag, " data_rdata"}, data_rdata, exp_rdata);
    chk({tag, " data_err"}, {31'd0, data_err}, {31'd0, exp_err});
    chk({tag, " instr_rvalid"}, {31'd0, instr_rvalid}, 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[32] = 32'h0000_0013;
    mem_rdata = 32'h0;
    rst = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h80;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h100; data_wdata = 32'h0;

    // Reset with both requests asserted: everything stays quiet.
    tick();
    tick();
    chk_all_zero("reset");
    instr_req = 1'b0; data_req = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("idle");
    tick();

    // Solo fetch of 0x80.
    instr_req = 1'b1; instr_addr = 32'h80;
    #1;
    chk("fetch instr_gnt", {31'd0, instr_gnt}, 32'd1);
    chk("fetch mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch mem_addr", mem_addr, 32'h80);
    chk("fetch mem_we_be", {27'd0, mem_we, mem_be}, 32'h0000_000F);
    chk("fetch mem_wdata", mem_wdata, 32'h0);
    tick();
    instr_req = 1'b0;
    #1;
    chk("fetch rvalid", {31'd0, instr_rvalid}, 32'd1);
    chk("fetch rdata", instr_rdata, 32'h0000_0013);
    chk("fetch err", {31'd0, instr_err}, 32'd0);
    chk("fetch data_rvalid", {31'd0, data_rvalid}, 32'd0);
    tick();

    // Stores and loads, including a partial byte write.
    data_txn("st_full", 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    data_txn("ld_full", 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    data_txn("st_byte", 1'b1, 4'h1, 32'h100, 32'h0000_00AA, 1'b1, 32'h0, 1'b0);
    data_txn("ld_byte", 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEAA, 1'b0);

    // Out-of-range load and out-of-range fetch.
    data_txn("ld_oor", 1'b0, 4'hF, 32'h0001_0000, 32'h0, 1'b0, 32'h0, 1'b1);
    instr_req = 1'b1; instr_addr = 32'h0002_0040;
    #1;
    chk("fetch_oor gnt", {31'd0, instr_gnt}, 32'd1);
    chk("fetch_oor mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    instr_req = 1'b0;
    #1;
    chk("fetch_oor rvalid", {31'd0, instr_rvalid}, 32'd1);
    chk("fetch_oor err", {31'd0, instr_err}, 32'd1);
    chk("fetch_oor rdata", instr_rdata, 32'h0);
    tick();

    // Grant followed immediately by reset: the pending response is dropped.
    instr_req = 1'b1; instr_addr = 32'h80;
    #1;
    chk("rst_drop gnt", {31'd0, instr_gnt}, 32'd1);
    tick();
    rst = 1'b1; instr_req = 1'b0;
    #1;
    chk("rst_drop rvalid0", {31'd0, instr_rvalid}, 32'd0);
    chk("rst_drop rdata0", instr_rdata, 32'h0);
    tick();
    chk("rst_drop rvalid1", {31'd0, instr_rvalid}, 32'd0);
    rst = 1'b0;
    #1;
    chk_all_zero("post_rst");
    tick();
    chk_all_zero("post_rst2");

    // Both requesting: instr wins four times, then data, repeating.
    instr_req = 1'b1; instr_addr = 32'h80;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h104;
    begin
      logic prev_d;
      prev_d = 1'b0;
      for (int i = 0; i < 10; i++) begin
        logic exp_d;
        exp_d = ((i % 5) == 4);
        #1;
        chk($sformatf("conflict%0d instr_gnt", i), {31'd0, instr_gnt}, {31'd0, !exp_d});
        chk($sformatf("conflict%0d data_gnt", i), {31'd0, data_gnt}, {31'd0, exp_d});
        if (i > 0) begin
          chk($sformatf("conflict%0d instr_rvalid", i), {31'd0, instr_rvalid}, {31'd0, !prev_d});
          chk($sformatf("conflict%0d data_rvalid", i), {31'd0, data_rvalid}, {31'd0, prev_d});
        end
        prev_d = exp_d;
        tick();
      end
    end

    // Three solo data grants after the conflict window.
    instr_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("solo%0d data_gnt", j), {31'd0, data_gnt}, 32'd1);
      chk($sformatf("solo%0d data_rvalid", j), {31'd0, data_rvalid}, 32'd1);
      tick();
    end
    data_req = 1'b0;
    #1;
    chk("solo_end data_rvalid", {31'd0, data_rvalid}, 32'd1);
    tick();
    chk_all_zero("final_idle");

`ifdef IBEX_ARB_PERF_EN
    chk("perf_conflict", perf_conflict, 32'd10);
    chk("perf_instr_gnt", perf_instr_gnt, 32'd8);
    chk("perf_data_gnt", perf_data_gnt, 32'd5);
    chk("perf_total_gnt", perf_instr_gnt + perf_data_gnt, 32'd13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
